// File: rtl/digit_scan_pkg.sv
// Shared types, defaults and digit-order helpers for the digit scan controller.
package digit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam int PRESCALE_DEF     = 1000;
    localparam int BLANK_CYCLES_DEF = 16;

    // Next enabled digit after cur, wrapping 3 -> 0; returns cur if none enabled.
    function automatic logic [1:0] next_digit(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] d;
        logic       found;
        next_digit = cur;
        d          = cur;
        found      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = d + 2'd1;
            if (!found && mask[d]) begin
                next_digit = d;
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] first_digit(input logic [3:0] mask);
        first_digit = next_digit(2'd3, mask);
    endfunction

    function automatic logic [1:0] last_digit(input logic [3:0] mask);
        last_digit = 2'd0;
        for (int i = 0; i < 4; i++)
            if (mask[i]) last_digit = 2'(i);
    endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// Loadable up-counter with terminal-count flag; load clears to 0 and wins over count.
module scan_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scan controller (IDLE/SHOW/BLANK), registered outputs.
// Optional macro DIGIT_SCAN_MASK_EN adds digit_mask[3:0] to skip disabled digits.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int PRESCALE     = PRESCALE_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
`ifdef DIGIT_SCAN_MASK_EN
    input  logic [3:0] digit_mask,
`endif
    output logic [1:0] select,
    output logic       enable,
    output logic       digit_strobe,
    output logic       frame_done
);

    localparam int CW    = $clog2(PRESCALE);
    localparam int BW    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [CW-1:0] S_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] S_PEN  = CW'(PRESCALE - 2);
    localparam logic [BW-1:0] B_LAST = BW'(BLAST);

    scan_state_e state, state_nxt;
    logic [1:0]  sel_nxt;
    logic        en_nxt, strobe_nxt, fdone_nxt;
    logic [3:0]  mask;
    logic        stop;

    logic [CW-1:0] show_cnt;
    logic [BW-1:0] blank_cnt;
    logic          show_tc, blank_tc;

`ifdef DIGIT_SCAN_MASK_EN
    assign mask = digit_mask;
`else
    assign mask = 4'hF;
`endif

    // An empty mask parks the scanner exactly like run=0.
    assign stop = !run || (mask == 4'h0);

    scan_tick_counter #(.W(CW)) u_show_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state != SHOW) || show_tc || stop),
        .en    (state == SHOW),
        .last  (S_LAST),
        .cnt   (show_cnt),
        .tc    (show_tc)
    );

    scan_tick_counter #(.W(BW)) u_blank_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state != BLANK) || blank_tc || stop),
        .en    (state == BLANK),
        .last  (B_LAST),
        .cnt   (blank_cnt),
        .tc    (blank_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            select       <= 2'd0;
            enable       <= 1'b1;
            digit_strobe <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            select       <= sel_nxt;
            enable       <= en_nxt;
            digit_strobe <= strobe_nxt;
            frame_done   <= fdone_nxt;
        end
    end

    // Outputs are registered, so each pulse is decided one cycle ahead of where it appears.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = select;
        en_nxt     = enable;
        strobe_nxt = 1'b0;
        fdone_nxt  = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            sel_nxt   = 2'd0;
            en_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SHOW;
                    sel_nxt    = first_digit(mask);
                    en_nxt     = 1'b0;
                    strobe_nxt = 1'b1;
                end
                SHOW: begin
                    if (show_tc) begin
                        if (BLANK_CYCLES == 0) begin
                            sel_nxt    = next_digit(select, mask);
                            strobe_nxt = 1'b1;
                        end else begin
                            state_nxt = BLANK;
                            en_nxt    = 1'b1;
                        end
                    end else if (show_cnt == S_PEN && select == last_digit(mask)) begin
                        fdone_nxt = 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_tc) begin
                        state_nxt  = SHOW;
                        sel_nxt    = next_digit(select, mask);
                        en_nxt     = 1'b0;
                        strobe_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    sel_nxt   = 2'd0;
                    en_nxt    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench: dut_a (PRESCALE=4, BLANK_CYCLES=1) and dut_b (PRESCALE=2, BLANK_CYCLES=0).
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_a = 1'b0, run_b = 1'b0;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b, stb_a, stb_b, fd_a, fd_b;
`ifdef DIGIT_SCAN_MASK_EN
    logic [3:0] mask_a = 4'hF, mask_b = 4'hF;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run_a),
`ifdef DIGIT_SCAN_MASK_EN
        .digit_mask   (mask_a),
`endif
        .select       (sel_a),
        .enable       (en_a),
        .digit_strobe (stb_a),
        .frame_done   (fd_a)
    );

    digit_scan_ctrl #(.PRESCALE(2), .BLANK_CYCLES(0)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run_b),
`ifdef DIGIT_SCAN_MASK_EN
        .digit_mask   (mask_b),
`endif
        .select       (sel_b),
        .enable       (en_b),
        .digit_strobe (stb_b),
        .frame_done   (fd_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed compare of {select, enable, digit_strobe, frame_done}.
    task automatic chk_a(input string tag, input logic [1:0] s, input logic e, input logic st, input logic fd);
        check(tag, {3'b0, sel_a, en_a, stb_a, fd_a}, {3'b0, s, e, st, fd});
    endtask

    task automatic chk_b(input string tag, input logic [1:0] s, input logic e, input logic st, input logic fd);
        check(tag, {3'b0, sel_b, en_b, stb_b, fd_b}, {3'b0, s, e, st, fd});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         k, d;
        logic [1:0] dd;

        // Reset held across clock edges
        #23;
        chk_a("reset_a", 2'd0, 1'b1, 1'b0, 1'b0);
        chk_b("reset_b", 2'd0, 1'b1, 1'b0, 1'b0);
        check("reset_cnt_a", 8'(dut_a.u_show_cnt.cnt), 8'd0);

        // Release reset with run=1: first SHOW on the very next edge
        #4;
        rst_n = 1'b1;
        run_a = 1'b1;
        run_b = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            k  = (c - 1) % 5;
            d  = ((c - 1) / 5) % 4;
            dd = 2'(d);
            if (k < 4) chk_a($sformatf("scan_a_c%0d", c), dd, 1'b0, k == 0, (k == 3) && (d == 3));
            else       chk_a($sformatf("scan_a_c%0d", c), dd, 1'b1, 1'b0, 1'b0);
            k  = (c - 1) % 2;
            d  = ((c - 1) / 2) % 4;
            dd = 2'(d);
            chk_b($sformatf("scan_b_c%0d", c), dd, 1'b0, k == 0, (k == 1) && (d == 3));
        end

        // Drop run: both go idle next cycle
        run_a = 1'b0;
        run_b = 1'b0;
        tick();
        chk_a("idle_a", 2'd0, 1'b1, 1'b0, 1'b0);
        chk_b("idle_b", 2'd0, 1'b1, 1'b0, 1'b0);
        check("idle_cnt_a", 8'(dut_a.u_show_cnt.cnt), 8'd0);

        // run dropped in 2nd SHOW cycle of digit 2
        run_a = 1'b1;
        for (int c = 1; c <= 12; c++) tick();
        chk_a("d2_show2", 2'd2, 1'b0, 1'b0, 1'b0);
        run_a = 1'b0;
        tick();
        chk_a("abort_idle", 2'd0, 1'b1, 1'b0, 1'b0);
        run_a = 1'b1;
        tick();
        chk_a("restart_d0", 2'd0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-BLANK (blank after digit 1 is cycle 10)
        for (int c = 2; c <= 10; c++) tick();
        chk_a("blank_d1", 2'd1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst_blank", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_a("rst_hold", 2'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_a("post_rst_d0", 2'd0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-SHOW of digit 1 forces enable high without an edge
        for (int c = 2; c <= 7; c++) tick();
        chk_a("show_d1", 2'd1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst_show", 2'd0, 1'b1, 1'b0, 1'b0);
        run_a = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_a("idle_after_rst", 2'd0, 1'b1, 1'b0, 1'b0);

`ifdef DIGIT_SCAN_MASK_EN
        // Empty mask parks the scanner, then it resumes at the lowest enabled digit
        mask_a = 4'b0000;
        run_a  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_a($sformatf("mask0_c%0d", c), 2'd0, 1'b1, 1'b0, 1'b0);
        end
        mask_a = 4'b1010;
        tick();
        chk_a("mask_c1", 2'd1, 1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (c == 6)  chk_a("mask_c6", 2'd3, 1'b0, 1'b1, 1'b0);
            if (c == 9)  chk_a("mask_c9", 2'd3, 1'b0, 1'b0, 1'b1);
            if (c == 11) chk_a("mask_c11", 2'd1, 1'b0, 1'b1, 1'b0);
            if (c == 16) chk_a("mask_c16", 2'd3, 1'b0, 1'b1, 1'b0);
        end
        run_a = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1000, giving the clock cycles each digit is shown (legal range 2..65535).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, giving the blanking cycles between digits (legal range 0..255).
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port run  input  1  scan enable; 1 = scan, 0 = idle and blanked.
REQ-006 Port select  output  2  digit index for the downstream 2-to-4 decoder.
REQ-007 Port enable  output  1  decoder disable, 1 = all decoder outputs 0, matching the decoder's active-high blank input.
REQ-008 Port digit_strobe  output  1  one-cycle pulse on the first cycle a digit is shown.
REQ-009 Port frame_done  output  1  one-cycle pulse when the last digit of a frame finishes showing.

Function
REQ-010 The block SHALL implement states IDLE, SHOW, BLANK in a registered state machine, with all outputs driven from registers.
REQ-011 In IDLE, outputs SHALL be enable=1 and select=0, and the cycle counter SHALL be 0.
REQ-012 IDLE -> SHOW SHALL occur on the first clock edge with run=1, with select=0 and digit_strobe=1 in the first SHOW cycle.
REQ-013 SHOW SHALL last exactly PRESCALE cycles, with enable=0 and select constant.
REQ-014 After SHOW, the block SHALL enter BLANK for exactly BLANK_CYCLES cycles, with enable=1 and select unchanged; if BLANK_CYCLES=0, BLANK SHALL be skipped.
REQ-015 Leaving BLANK (or SHOW when BLANK_CYCLES=0), select SHALL advance by 1, wrapping 3 -> 0, and the next SHOW begins with digit_strobe=1.
REQ-016 frame_done SHALL pulse in the last SHOW cycle of digit 3 (or of the last enabled digit under REQ-022).
REQ-017 When run=0 is sampled in any state, the next cycle SHALL be IDLE with enable=1 and select=0; no frame_done SHALL be emitted.
REQ-018 The cycle counter SHALL be ceil(log2(PRESCALE)) bits wide, reset to 0 on every state entry, and SHALL never exceed PRESCALE-1.

Reset
REQ-019 While rst_n=0, the block SHALL hold state=IDLE, select=0, enable=1, digit_strobe=0, frame_done=0, and counter=0, regardless of clk.
REQ-020 After rst_n deasserts with run=1, the first SHOW (digit 0) SHALL begin on the first clock edge after deassertion.
REQ-021 Reset asserted mid-SHOW SHALL force enable=1 immediately (asynchronously), with no glitch on select beyond the value 0.

Configuration
REQ-022 With macro DIGIT_SCAN_MASK_EN defined, input digit_mask[3:0] SHALL exist and digits with a mask bit of 0 SHALL be skipped; without the macro, the port SHALL be absent and all four digits scanned.
REQ-023 With DIGIT_SCAN_MASK_EN defined and digit_mask=0, the block SHALL remain with enable=1 and emit no strobes, and SHALL resume at the lowest enabled digit once the mask becomes non-zero.

Structure
REQ-024 Package digit_scan_pkg SHALL hold the state enum (IDLE, SHOW, BLANK) and the default PRESCALE/BLANK_CYCLES constants.
REQ-025 Cycle counting SHALL be in sub-module scan_tick_counter (load, count, terminal-count output); the FSM stays in digit_scan_ctrl.

Verification
REQ-026 Reset, then run=1 with PRESCALE=4 and BLANK_CYCLES=1 -> select sequence 0,0,0,0,(blank),1,... with digit_strobe on cycles 1, 6, 11, 16.
REQ-027 Full frame, PRESCALE=4 and BLANK_CYCLES=1 -> frame_done single pulse in cycle 19; select wraps to 0 in cycle 21.
REQ-028 BLANK_CYCLES=0 and PRESCALE=2 -> select advances every 2 cycles and enable never rises while run=1.
REQ-029 run dropped in the 2nd SHOW cycle of digit 2 -> next cycle enable=1, select=0, no frame_done; run reasserted -> restart at digit 0.
REQ-030 rst_n pulsed low mid-BLANK -> outputs at reset values asynchronously, then a clean restart at digit 0.
REQ-031 DIGIT_SCAN_MASK_EN with digit_mask=4'b1010 -> select visits 1,3,1,3, and frame_done follows digit 3.
